gs_imem_arbiter: RTL and testbench

- Shares the single instruction/data SRAM port between the prefetch (instruction-fetch) requester and the load/store unit.
- Serialises accesses one at a time. Drives SRAM address, active-low byte write enables and write data. Routes read data back to the requester that owns the access.
- Sits between the prefetch controller and LSU on one side and the memory macro on the other.

---
 rtl/gs_pkg.sv | 18 +
 rtl/gs_arb_pick.sv | 40 ++++
 rtl/gs_imem_arbiter.sv | 172 +++++++++++++++++
 tb/tb_gs_imem_arbiter.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gs_pkg.sv
// gs_pkg: shared types and constants for the instruction/data SRAM arbiter.
package gs_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } arb_owner_t;

    localparam int         GS_MEM_LAT_DEFAULT = 1;
    localparam logic [3:0] GS_WEB_READ        = 4'hF;

endpackage

// File: rtl/gs_arb_pick.sv
// gs_arb_pick: combinational winner selection between fetch and LSU.
// Optional macro GS_ARB_ROUND_ROBIN_EN: alternate winners on ties
// instead of fixed LSU priority with the starvation override.
module gs_arb_pick
    import gs_pkg::*;
(
    input  logic       if_req,
    input  logic       ls_req,
    input  logic       starve_hit,
    input  arb_owner_t last_owner,
    output arb_owner_t winner
);

    logic unused_inputs;

`ifdef GS_ARB_ROUND_ROBIN_EN
    assign unused_inputs = starve_hit;

    // A tie goes to whichever requester did not own the previous grant.
    always_comb begin
        winner = OWN_LS;
        if (if_req && !ls_req) begin
            winner = OWN_IF;
        end else if (if_req && ls_req) begin
            winner = (last_owner == OWN_LS) ? OWN_IF : OWN_LS;
        end
    end
`else
    assign unused_inputs = last_owner;

    // LSU wins ties unless fetch has been passed over too many times in a row.
    always_comb begin
        winner = OWN_LS;
        if (if_req && (!ls_req || starve_hit)) begin
            winner = OWN_IF;
        end
    end
`endif

endmodule

// File: rtl/gs_imem_arbiter.sv
// gs_imem_arbiter: serialises fetch and LSU accesses onto one SRAM port,
// one outstanding access at a time, and routes read data back to the owner.
// Optional macro GS_ARB_ROUND_ROBIN_EN replaces the starvation counter with
// round-robin tie breaking.
module gs_imem_arbiter
    import gs_pkg::*;
#(
    parameter int MEM_LAT    = GS_MEM_LAT_DEFAULT,
    parameter int STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    input  logic        ls_req_i,
    input  logic        ls_we_i,
    input  logic [3:0]  ls_be_i,
    input  logic [31:0] ls_addr_i,
    input  logic [31:0] ls_wdata_i,
    output logic        ls_gnt_o,
    output logic        ls_rvalid_o,
    output logic [31:0] ls_rdata_o,
    output logic        mem_cs_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_web_o,
    output logic [31:0] mem_wdata_o,
    input  logic [31:0] mem_rdata_i
);

    localparam logic [1:0] LAT_LOAD = 2'(MEM_LAT - 1);

    arb_state_t state;
    arb_state_t state_next;
    arb_owner_t owner;
    arb_owner_t winner;
    logic       grant;
    logic       we_q;
    logic [1:0] lat_cnt;
    logic       starve_hit;
    logic       unused_addr_bits;

    assign unused_addr_bits = ^{if_addr_i[1:0], ls_addr_i[1:0]};

    gs_arb_pick u_pick (
        .if_req     (if_req_i),
        .ls_req     (ls_req_i),
        .starve_hit (starve_hit),
        .last_owner (owner),
        .winner     (winner)
    );

`ifdef GS_ARB_ROUND_ROBIN_EN
    localparam int unused_starve_max = STARVE_MAX;
    assign starve_hit = 1'b0;
`else
    localparam int         SCW        = ($clog2(STARVE_MAX + 1) < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0] STARVE_LIM = SCW'(STARVE_MAX);

    logic [SCW-1:0] starve_cnt;

    assign starve_hit = (starve_cnt >= STARVE_LIM);

    // Count LSU grants that bypassed a waiting fetch; any other grant clears it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (grant) begin
            if (winner == OWN_LS && if_req_i) begin
                if (starve_cnt != STARVE_LIM) begin
                    starve_cnt <= starve_cnt + SCW'(1);
                end
            end else begin
                starve_cnt <= '0;
            end
        end
    end
`endif

    // State register for the idle/issue/wait access sequence.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, grants, SRAM strobe and read-data routing.
    always_comb begin
        state_next  = state;
        grant       = 1'b0;
        if_gnt_o    = 1'b0;
        ls_gnt_o    = 1'b0;
        mem_cs_o    = 1'b0;
        if_rvalid_o = 1'b0;
        ls_rvalid_o = 1'b0;
        if_rdata_o  = '0;
        ls_rdata_o  = '0;
        case (state)
            ARB_IDLE: begin
                if (rst && (if_req_i || ls_req_i)) begin
                    grant      = 1'b1;
                    state_next = ARB_ISSUE;
                    if (winner == OWN_IF) begin
                        if_gnt_o = 1'b1;
                    end else begin
                        ls_gnt_o = 1'b1;
                    end
                end
            end
            ARB_ISSUE: begin
                mem_cs_o   = 1'b1;
                state_next = ARB_WAIT;
            end
            ARB_WAIT: begin
                if (lat_cnt == 2'd0) begin
                    state_next = ARB_IDLE;
                    if (rst) begin
                        if (owner == OWN_IF) begin
                            if_rvalid_o = 1'b1;
                            if_rdata_o  = mem_rdata_i;
                        end else begin
                            ls_rvalid_o = 1'b1;
                            ls_rdata_o  = we_q ? 32'h0 : mem_rdata_i;
                        end
                    end
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Capture the winner's access at grant; SRAM-facing fields hold until the next grant.
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner       <= OWN_IF;
            we_q        <= 1'b0;
            mem_addr_o  <= '0;
            mem_web_o   <= GS_WEB_READ;
            mem_wdata_o <= '0;
        end else if (grant) begin
            owner <= winner;
            if (winner == OWN_LS) begin
                we_q        <= ls_we_i;
                mem_addr_o  <= {ls_addr_i[31:2], 2'b00};
                mem_web_o   <= ls_we_i ? ~ls_be_i : GS_WEB_READ;
                mem_wdata_o <= ls_wdata_i;
            end else begin
                we_q       <= 1'b0;
                mem_addr_o <= {if_addr_i[31:2], 2'b00};
                mem_web_o  <= GS_WEB_READ;
            end
        end
    end

    // Latency countdown from the strobe cycle to the read-data cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            lat_cnt <= 2'd0;
        end else if (state == ARB_ISSUE) begin
            lat_cnt <= LAT_LOAD;
        end else if (state == ARB_WAIT && lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 2'd1;
        end
    end

endmodule

// File: tb/tb_gs_imem_arbiter.sv
// tb_gs_imem_arbiter: randomized and directed checks of gs_imem_arbiter
// against a transaction-level reference model with its own memory image.
module tb_gs_imem_arbiter;

    localparam int LAT        = 1;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, if_gnt, if_rvalid;
    logic [31:0] if_addr, if_rdata;
    logic        ls_req, ls_we, ls_gnt, ls_rvalid;
    logic [3:0]  ls_be;
    logic [31:0] ls_addr, ls_wdata, ls_rdata;
    logic        mem_cs;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_web;

    logic        if3_req, if3_gnt, if3_rvalid;
    logic [31:0] if3_addr, if3_rdata;
    logic        ls3_req, ls3_we, ls3_gnt, ls3_rvalid;
    logic [3:0]  ls3_be;
    logic [31:0] ls3_addr, ls3_wdata, ls3_rdata;
    logic        mem3_cs;
    logic [31:0] mem3_addr, mem3_wdata, mem3_rdata;
    logic [3:0]  mem3_web;

    always #5 clk = ~clk;

    gs_imem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata),
        .ls_req_i(ls_req), .ls_we_i(ls_we), .ls_be_i(ls_be), .ls_addr_i(ls_addr),
        .ls_wdata_i(ls_wdata), .ls_gnt_o(ls_gnt), .ls_rvalid_o(ls_rvalid), .ls_rdata_o(ls_rdata),
        .mem_cs_o(mem_cs), .mem_addr_o(mem_addr), .mem_web_o(mem_web),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    gs_imem_arbiter #(.MEM_LAT(3), .STARVE_MAX(STARVE_MAX)) dut3 (
        .clk(clk), .rst(rst),
        .if_req_i(if3_req), .if_addr_i(if3_addr), .if_gnt_o(if3_gnt),
        .if_rvalid_o(if3_rvalid), .if_rdata_o(if3_rdata),
        .ls_req_i(ls3_req), .ls_we_i(ls3_we), .ls_be_i(ls3_be), .ls_addr_i(ls3_addr),
        .ls_wdata_i(ls3_wdata), .ls_gnt_o(ls3_gnt), .ls_rvalid_o(ls3_rvalid), .ls_rdata_o(ls3_rdata),
        .mem_cs_o(mem3_cs), .mem_addr_o(mem3_addr), .mem_web_o(mem3_web),
        .mem_wdata_o(mem3_wdata), .mem_rdata_i(mem3_rdata)
    );

    // SRAM stand-in for the latency-1 instance: reads return one cycle after
    // the strobe, anything else drives junk so idle data gating is visible.
    logic [31:0] sram [16];
    logic [31:0] sram_next;
    logic [31:0] ref_mem [16];
    logic        load_mem;

    always @(negedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) sram[i] <= ref_mem[i];
            sram_next <= $urandom;
        end else if (mem_cs && mem_web == 4'hF) begin
            sram_next <= sram[mem_addr[5:2]];
        end else begin
            if (mem_cs) begin
                for (int b = 0; b < 4; b++)
                    if (!mem_web[b]) sram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
            sram_next <= $urandom;
        end
    end

    always @(posedge clk) mem_rdata <= sram_next;

    // Reference model state: cycles since the last grant, captured transaction,
    // fetch-bypass count and last owner.
    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    int          since = -1;
    int          starve = 0;
    bit          last_ls = 1'b0;
    bit          t_ls, t_we;
    logic [3:0]  t_be;
    logic [31:0] t_addr, t_wdata;
    logic [31:0] m_addr = 32'h0;
    logic [3:0]  m_web = 4'hF;
    bit          exp_if_gnt = 1'b0;
    bit          exp_ls_gnt = 1'b0;
    byte         obs_grants[$];
    int          obs_cycles[$];

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock of checking: predict outputs from the model, compare at the
    // falling edge, advance the model to the next rising edge.
    task automatic modelCycle();
        bit          e_cs, e_ifrv, e_lsrv, win_if;
        logic [31:0] e_ifrd, e_lsrd;
        e_cs = 0; e_ifrv = 0; e_lsrv = 0; e_ifrd = 0; e_lsrd = 0; win_if = 0;
        exp_if_gnt = 0; exp_ls_gnt = 0;
        @(negedge clk);
        if (since < 0) begin
            if (rst && (if_req || ls_req)) begin
`ifdef GS_ARB_ROUND_ROBIN_EN
                win_if = if_req && (!ls_req || last_ls);
`else
                win_if = if_req && (!ls_req || starve >= STARVE_MAX);
`endif
                exp_if_gnt = win_if;
                exp_ls_gnt = !win_if;
            end
        end else if (since == 1) begin
            e_cs = 1;
        end else if (since == 1 + LAT && rst) begin
            if (t_ls) begin
                e_lsrv = 1;
                e_lsrd = t_we ? 32'h0 : ref_mem[t_addr[5:2]];
            end else begin
                e_ifrv = 1;
                e_ifrd = ref_mem[t_addr[5:2]];
            end
        end
        if (if_gnt) begin obs_grants.push_back("I"); obs_cycles.push_back(cyc); end
        if (ls_gnt) begin obs_grants.push_back("L"); obs_cycles.push_back(cyc); end
        checkOutput("if_gnt", 32'(if_gnt), 32'(exp_if_gnt));
        checkOutput("ls_gnt", 32'(ls_gnt), 32'(exp_ls_gnt));
        checkOutput("mem_cs", 32'(mem_cs), 32'(e_cs));
        checkOutput("if_rvalid", 32'(if_rvalid), 32'(e_ifrv));
        checkOutput("if_rdata", if_rdata, e_ifrd);
        checkOutput("ls_rvalid", 32'(ls_rvalid), 32'(e_lsrv));
        checkOutput("ls_rdata", ls_rdata, e_lsrd);
        checkOutput("mem_addr", mem_addr, m_addr);
        checkOutput("mem_web", 32'(mem_web), 32'(m_web));
        if (e_cs && t_ls && t_we) checkOutput("mem_wdata", mem_wdata, t_wdata);
        if (since == 1 && t_ls && t_we) begin
            for (int b = 0; b < 4; b++)
                if (t_be[b]) ref_mem[t_addr[5:2]][8*b +: 8] = t_wdata[8*b +: 8];
        end
        if (!rst) begin
            since = -1; starve = 0; last_ls = 0; m_addr = 0; m_web = 4'hF;
        end else if (exp_if_gnt || exp_ls_gnt) begin
            t_ls = exp_ls_gnt;
            if (t_ls) begin
                t_we = ls_we; t_be = ls_be; t_addr = ls_addr; t_wdata = ls_wdata;
                starve = if_req ? starve + 1 : 0;
            end else begin
                t_we = 0; t_be = 4'h0; t_addr = if_addr; t_wdata = 0;
                starve = 0;
            end
            last_ls = t_ls;
            m_addr  = {t_addr[31:2], 2'b00};
            m_web   = (t_ls && t_we) ? ~t_be : 4'hF;
            since   = 1;
        end else if (since >= 0) begin
            since = (since == 1 + LAT) ? -1 : since + 1;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Random requesters that respect the hold-until-grant protocol.
    task automatic applyStimulus();
        if (exp_if_gnt || !if_req) begin
            if_req  = ($urandom_range(0, 2) != 0);
            if_addr = $urandom;
        end
        if (exp_ls_gnt || !ls_req) begin
            ls_req   = ($urandom_range(0, 2) != 0);
            ls_we    = $urandom_range(0, 1) == 1;
            ls_be    = 4'($urandom);
            ls_addr  = $urandom;
            ls_wdata = $urandom;
        end
    endtask

    initial begin
        string exp_order;
`ifdef GS_ARB_ROUND_ROBIN_EN
        exp_order = "LILILILI";
`else
        exp_order = "LLLILLLI";
`endif
        rst = 0; load_mem = 1;
        if_req = 0; if_addr = 0; ls_req = 0; ls_we = 0; ls_be = 0; ls_addr = 0; ls_wdata = 0;
        if3_req = 0; if3_addr = 0; ls3_req = 0; ls3_we = 0; ls3_be = 0; ls3_addr = 0; ls3_wdata = 0;
        mem3_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 16; i++) ref_mem[i] = $urandom;
        ref_mem[1] = 32'hDEAD_BEEF;
        repeat (2) @(posedge clk);
        #1;
        load_mem = 0;

        // Reset values with reset still held.
        modelCycle();
        checkOutput("reset_wdata", mem_wdata, 32'h0);
        rst = 1;
        modelCycle();

        // Fetch-only read of 0x104.
        if_req = 1; if_addr = 32'h0000_0104;
        modelCycle();
        if_req = 0;
        repeat (3) modelCycle();

        // LSU byte write at 0x2003.
        ls_req = 1; ls_we = 1; ls_be = 4'b0011; ls_addr = 32'h0000_2003; ls_wdata = 32'h1234_5678;
        modelCycle();
        ls_req = 0;
        repeat (3) modelCycle();

        // Continuous contention from a fresh reset.
        rst = 0;
        modelCycle();
        rst = 1;
        obs_grants.delete(); obs_cycles.delete();
        if_req = 1; if_addr = 32'h0000_0010;
        ls_req = 1; ls_we = 0; ls_be = 4'hF; ls_addr = 32'h0000_0020;
        for (int k = 0; k < 30 && obs_grants.size() < 8; k++) modelCycle();
        if_req = 0; ls_req = 0;
        repeat (3) modelCycle();
        checkOutput("grant_count", 32'(obs_grants.size() >= 8), 32'h1);
        for (int i = 0; i < 8 && i < obs_grants.size(); i++) begin
            byte e;
            e = exp_order[i];
            checkOutput("grant_order", 32'(obs_grants[i]), 32'(e));
            if (i > 0) checkOutput("grant_spacing", 32'(obs_cycles[i] - obs_cycles[i-1]), 32'(LAT + 2));
        end

        // Reset lands one cycle after an LSU read grant.
        ls_req = 1; ls_we = 0; ls_addr = 32'h0000_0008;
        modelCycle();
        ls_req = 0; if_req = 1; if_addr = 32'h0000_0030; rst = 0;
        modelCycle();
        modelCycle();
        checkOutput("reset_mid_wdata", mem_wdata, 32'h0);
        rst = 1;
        modelCycle();
        if_req = 0;
        repeat (4) modelCycle();

        // Randomized traffic.
        for (int k = 0; k < 500; k++) begin
            applyStimulus();
            modelCycle();
        end
        if_req = 0; ls_req = 0;
        repeat (4) modelCycle();

        // Latency-3 instance: data at T+4, next grant no earlier than T+5.
        if3_req = 1; if3_addr = 32'h0000_0041;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checkOutput("lat3_gnt", 32'(if3_gnt), 32'(k == 0 || k == 5));
            checkOutput("lat3_cs", 32'(mem3_cs), 32'(k == 1 || k == 6));
            checkOutput("lat3_rvalid", 32'(if3_rvalid), 32'(k == 4));
            checkOutput("lat3_rdata", if3_rdata, (k == 4) ? 32'hCAFE_F00D : 32'h0);
            if (k == 1) checkOutput("lat3_addr", mem3_addr, 32'h0000_0040);
            @(posedge clk);
            #1;
            if (k == 5) if3_req = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
